// File: rtl/ir_cmd_pkg.sv
// ir_cmd_pkg
// Shared definitions for the IR command dispatcher: FSM state encoding,
// Avalon register addresses, status/control/clear bit positions and the
// default remote custom code.
package ir_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        PUSH  = 2'd2,
        DROP  = 2'd3
    } ir_state_t;

    // Register map
    localparam logic [1:0] ADDR_FIFO   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_RSVD   = 2'd3;

    // Status word fields
    localparam int STAT_OVF_BIT   = 31;
    localparam int STAT_DROP_LSB  = 16;
    localparam int STAT_FULL_BIT  = 6;
    localparam int STAT_EMPTY_BIT = 5;
    localparam int STAT_CNT_LSB   = 0;

    // Status clear word (write to ADDR_STATUS)
    localparam int CLR_OVF_BIT  = 0;
    localparam int CLR_DROP_BIT = 1;

    // Control register fields
    localparam int CTRL_IRQ_EN_BIT    = 0;
    localparam int CTRL_FILTER_EN_BIT = 1;

    localparam logic [15:0] DEFAULT_CUSTOM_CODE = 16'h6B86;

endpackage

// File: rtl/ir_cmd_fifo.sv
// ir_cmd_fifo
// Synchronous single-clock FIFO. A push while full and a pop while empty
// are ignored, so callers may request either at any time.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   push, wdata     write request and data
//   pop             read request; rdata always shows the head entry
//   full, empty     occupancy flags
//   count           number of stored entries (0..DEPTH)
module ir_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 24
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/ir_cmd_dispatcher.sv
// ir_cmd_dispatcher
// Validates frames from an IR receiver, suppresses key auto-repeat within a
// hold window, and queues accepted commands for a CPU over an Avalon slave.
// Ports:
//   clk, reset                  50 MHz clock, synchronous active-high reset
//   rx_valid, rx_data[31:0]     frame strobe and data {~key, key, custom}
//   s_cs_n, s_address[1:0]      Avalon chip select (active low), register
//   s_read, s_write             access strobes
//   s_writedata[31:0]           write data
//   s_readdata[31:0]            registered read data, held until next read
//   irq                         registered level interrupt
module ir_cmd_dispatcher
    import ir_cmd_pkg::*;
#(
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [15:0] CUSTOM_CODE = DEFAULT_CUSTOM_CODE,
    parameter int          HOLD_CYCLES = 5_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [31:0] rx_data,
    input  logic        s_cs_n,
    input  logic [1:0]  s_address,
    input  logic        s_read,
    input  logic        s_write,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    output logic        irq
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = $clog2(HOLD_CYCLES + 1);

    // Handshake: rx_valid is a single-cycle strobe with no back-pressure;
    // a frame is taken only in IDLE, anything arriving while busy is lost
    // and flagged as overflow.
    ir_state_t     state, state_next;
    logic [31:0]   frame_q;
    logic [TW-1:0] hold_timer;
    logic [7:0]    last_key;
    logic          overflow;
    logic [7:0]    drop_count;
    logic          irq_en;
    logic          filter_en;

    logic          capture, push_req, drop_evt;
    logic          frame_ok, suppressed;
    logic          rd_en, wr_en, pop_req, push_ok, set_ovf;
    logic          clr_ovf, clr_drop;
    logic [31:0]   status_word, ctrl_word;

    logic [23:0]   fifo_rdata;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;

    logic          unused_wdata;
    assign unused_wdata = ^s_writedata[31:2];

    assign rd_en    = ~s_cs_n & s_read;
    assign wr_en    = ~s_cs_n & s_write;
    assign pop_req  = rd_en & (s_address == ADDR_FIFO);
    assign clr_ovf  = wr_en & (s_address == ADDR_STATUS) & s_writedata[CLR_OVF_BIT];
    assign clr_drop = wr_en & (s_address == ADDR_STATUS) & s_writedata[CLR_DROP_BIT];

    assign frame_ok   = (frame_q[31:24] == ~frame_q[23:16]) &&
                        (!filter_en || frame_q[15:0] == CUSTOM_CODE);
    assign suppressed = (frame_q[23:16] == last_key) && (hold_timer != '0);

    assign push_ok = push_req & ~fifo_full;
    // Overflow sources: a frame arriving while busy, or a push into a full FIFO.
    assign set_ovf = (rx_valid && state != IDLE) | (push_req & fifo_full);

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        push_req   = 1'b0;
        drop_evt   = 1'b0;
        case (state)
            IDLE: begin
                if (rx_valid) begin
                    capture    = 1'b1;
                    state_next = CHECK;
                end
            end
            CHECK:   state_next = (frame_ok && !suppressed) ? PUSH : DROP;
            PUSH: begin
                push_req   = 1'b1;
                state_next = IDLE;
            end
            DROP: begin
                drop_evt   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_q    <= '0;
            hold_timer <= '0;
            last_key   <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
            irq_en     <= 1'b0;
            filter_en  <= 1'b1;
            s_readdata <= '0;
            irq        <= 1'b0;
        end else begin
            if (capture) frame_q <= rx_data;

            if (push_ok) begin
                hold_timer <= TW'(HOLD_CYCLES);
                last_key   <= frame_q[23:16];
            end else if (hold_timer != '0) begin
                hold_timer <= hold_timer - TW'(1);
            end

            // Setting wins over a same-cycle software clear.
            if (set_ovf)      overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;

            if (drop_evt) begin
                if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
            end else if (clr_drop) begin
                drop_count <= '0;
            end

            if (wr_en && s_address == ADDR_CTRL) begin
                irq_en    <= s_writedata[CTRL_IRQ_EN_BIT];
                filter_en <= s_writedata[CTRL_FILTER_EN_BIT];
            end

            if (rd_en) begin
                case (s_address)
                    ADDR_FIFO:   s_readdata <= fifo_empty ? 32'h0 : {1'b1, 7'b0, fifo_rdata};
                    ADDR_STATUS: s_readdata <= status_word;
                    ADDR_CTRL:   s_readdata <= ctrl_word;
                    default:     s_readdata <= 32'h0;
                endcase
            end

            irq <= irq_en & (~fifo_empty | overflow);
        end
    end

    always_comb begin
        status_word = '0;
        status_word[STAT_OVF_BIT]         = overflow;
        status_word[STAT_DROP_LSB +: 8]   = drop_count;
        status_word[STAT_FULL_BIT]        = fifo_full;
        status_word[STAT_EMPTY_BIT]       = fifo_empty;
        status_word[STAT_CNT_LSB +: 5]    = 5'(fifo_count);
        ctrl_word = '0;
        ctrl_word[CTRL_IRQ_EN_BIT]        = irq_en;
        ctrl_word[CTRL_FILTER_EN_BIT]     = filter_en;
    end

    ir_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (24)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_ok),
        .wdata ({frame_q[15:0], frame_q[23:16]}),
        .pop   (pop_req),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_ir_cmd_dispatcher.sv
module tb_ir_cmd_dispatcher;
    localparam int          DEPTH = 4;
    localparam int          H     = 2000;
    localparam logic [15:0] CODE  = 16'h6B86;
    localparam logic [1:0]  A_FIFO = 2'd0, A_STAT = 2'd1, A_CTRL = 2'd2, A_RSVD = 2'd3;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset;
    logic        rx_valid;
    logic [31:0] rx_data;
    logic        s_cs_n;
    logic [1:0]  s_address;
    logic        s_read;
    logic        s_write;
    logic [31:0] s_writedata;
    logic [31:0] s_readdata;
    logic        irq;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ir_cmd_dispatcher #(
        .FIFO_DEPTH  (DEPTH),
        .CUSTOM_CODE (CODE),
        .HOLD_CYCLES (H)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .s_cs_n      (s_cs_n),
        .s_address   (s_address),
        .s_read      (s_read),
        .s_write     (s_write),
        .s_writedata (s_writedata),
        .s_readdata  (s_readdata),
        .irq         (irq)
    );

    // ---------------- reference model / scoreboard ----------------
    logic [23:0] exp_q[$];      // {custom, key} in acceptance order
    bit          m_ovf;
    int          m_drops;
    logic [7:0]  m_last_key;
    int          m_last_push;   // rx cycle of the last accepted frame
    bit          m_irq_en;
    bit          m_filter_en;

    function automatic void model_reset();
        exp_q.delete();
        m_ovf       = 1'b0;
        m_drops     = 0;
        m_last_key  = 8'h00;
        m_last_push = -1000000;
        m_irq_en    = 1'b0;
        m_filter_en = 1'b1;
    endfunction

    // Frame offered at cycle r. The hold timer is loaded two cycles after the
    // frame is offered and checked one cycle after a later frame is offered,
    // so a repeat is suppressed while r - last_push <= H + 1.
    function automatic void model_frame(input logic [31:0] f, input int r, input int occ);
        logic [7:0] key;
        bit ok, supp;
        key  = f[23:16];
        ok   = (f[31:24] == ~key) && (!m_filter_en || f[15:0] == CODE);
        supp = (key == m_last_key) && ((r - m_last_push) <= H + 1);
        if (!ok || supp) begin
            if (m_drops < 255) m_drops++;
        end else if (occ >= DEPTH) begin
            m_ovf = 1'b1;
        end else begin
            exp_q.push_back({f[15:0], key});
            m_last_key  = key;
            m_last_push = r;
        end
    endfunction

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s = '0;
        s[31]    = m_ovf;
        s[23:16] = 8'(m_drops);
        s[6]     = (exp_q.size() == DEPTH);
        s[5]     = (exp_q.size() == 0);
        s[4:0]   = 5'(exp_q.size());
        return s;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send_frame(input logic [31:0] f);
        model_frame(f, cyc, exp_q.size());
        rx_data  = f;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        repeat (3) tick();
    endtask

    // Second frame offered while the first is still being processed.
    task automatic send_burst(input logic [31:0] f1, input logic [31:0] f2);
        model_frame(f1, cyc, exp_q.size());
        m_ovf    = 1'b1;
        rx_data  = f1;
        rx_valid = 1'b1;
        tick();
        rx_data  = f2;
        tick();
        rx_valid = 1'b0;
        repeat (2) tick();
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
        s_cs_n    = 1'b0;
        s_read    = 1'b1;
        s_address = a;
        tick();
        s_cs_n    = 1'b1;
        s_read    = 1'b0;
        d         = s_readdata;
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
        if (a == A_CTRL) begin
            m_irq_en    = d[0];
            m_filter_en = d[1];
        end
        if (a == A_STAT) begin
            if (d[0]) m_ovf = 1'b0;
            if (d[1]) m_drops = 0;
        end
        s_cs_n      = 1'b0;
        s_write     = 1'b1;
        s_address   = a;
        s_writedata = d;
        tick();
        s_cs_n      = 1'b1;
        s_write     = 1'b0;
    endtask

    task automatic do_pop(input string tag);
        logic [31:0] exp, d;
        exp = (exp_q.size() > 0) ? {8'h80, exp_q.pop_front()} : 32'h0;
        read_reg(A_FIFO, d);
        check(tag, d, exp);
    endtask

    // Frame whose PUSH/DROP cycle coincides with a FIFO pop.
    task automatic frame_with_pop(input logic [31:0] f, input string tag);
        int pre;
        logic [31:0] exp_rd;
        pre    = exp_q.size();
        exp_rd = (pre > 0) ? {8'h80, exp_q.pop_front()} : 32'h0;
        model_frame(f, cyc, pre);
        rx_data  = f;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        tick();
        s_cs_n    = 1'b0;
        s_read    = 1'b1;
        s_address = A_FIFO;
        tick();
        s_cs_n    = 1'b1;
        s_read    = 1'b0;
        check(tag, s_readdata, exp_rd);
        tick();
    endtask

    task automatic check_status(input string tag);
        logic [31:0] d;
        read_reg(A_STAT, d);
        check(tag, d, exp_status());
    endtask

    task automatic check_irq(input string tag);
        tick();
        check(tag, {31'b0, irq}, {31'b0, m_irq_en & ((exp_q.size() > 0) | m_ovf)});
    endtask

    function automatic logic [31:0] mk(input logic [7:0] k, input logic [15:0] c);
        return {~k, k, c};
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] d;
        logic [7:0]  k, inv;
        logic [15:0] c;
        int          op;

        reset = 1'b1; rx_valid = 1'b0; rx_data = '0; s_cs_n = 1'b1;
        s_address = '0; s_read = 1'b0; s_write = 1'b0; s_writedata = '0;
        model_reset();
        repeat (2) tick();
        reset = 1'b0;

        // Reset state
        check("reset_readdata", s_readdata, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);
        check_status("reset_status");
        read_reg(A_CTRL, d);
        check("reset_ctrl", d, 32'h2);
        read_reg(A_RSVD, d);
        check("addr3_zero", d, 32'h0);

        // Accepted frame, interrupt and pop
        write_reg(A_CTRL, 32'h3);
        send_frame(32'hE51A6B86);
        check_status("one_entry_status");
        check_irq("irq_after_push");
        read_reg(A_FIFO, d);
        void'(exp_q.pop_front());
        check("pop_first_frame", d, 32'h806B861A);
        check_irq("irq_after_pop");

        // Bad complement dropped; drop counter clear
        send_frame(32'h001A6B86);
        check_status("bad_complement_status");
        write_reg(A_STAT, 32'h2);
        check_status("drop_clear_status");

        // Auto-repeat suppression and hold expiry
        send_frame(mk(8'h33, CODE));
        repeat (1000) tick();
        send_frame(mk(8'h33, CODE));
        check_status("repeat_suppressed_status");
        repeat (H + 10) tick();
        send_frame(mk(8'h33, CODE));
        check_status("after_hold_status");
        do_pop("hold_pop0");
        do_pop("hold_pop1");
        write_reg(A_STAT, 32'h3);

        // Overfill: five distinct keys into four entries
        for (int i = 0; i < 5; i++) send_frame(mk(8'h40 + 8'(i), CODE));
        check_status("overfill_status");
        check_irq("irq_full");
        for (int i = 0; i < 4; i++) do_pop("overfill_pop");
        do_pop("empty_pop");
        check_status("drained_status");
        write_reg(A_STAT, 32'h1);
        check_status("ovf_clear_status");

        // Frame arriving while busy
        send_burst(mk(8'h50, CODE), mk(8'h51, CODE));
        check_status("busy_overflow_status");
        write_reg(A_STAT, 32'h1);

        // Chip select gating: read strobe without select must not pop
        s_cs_n = 1'b1; s_read = 1'b1; s_address = A_FIFO;
        tick();
        s_read = 1'b0;
        check_status("cs_gated_status");

        // Pop during PUSH with one entry, then pop during PUSH with none
        frame_with_pop(mk(8'h60, CODE), "pop_during_push");
        check_status("push_pop_count");
        do_pop("pop_new_key");
        frame_with_pop(mk(8'h61, CODE), "pop_empty_during_push");
        check_status("push_pop_empty_count");
        do_pop("pop_stored_key");

        // Filter disabled accepts foreign custom code; reset mid-frame
        write_reg(A_CTRL, 32'h0);
        send_frame(mk(8'h5A, 16'h1234));
        check_status("filter_off_status");
        rx_data  = mk(8'h77, CODE);
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        reset    = 1'b1;
        tick();
        reset    = 1'b0;
        model_reset();
        check("midframe_rst_readdata", s_readdata, 32'h0);
        check("midframe_rst_irq", {31'b0, irq}, 32'h0);
        repeat (3) tick();
        check_status("midframe_rst_status");
        read_reg(A_CTRL, d);
        check("midframe_rst_ctrl", d, 32'h2);

        // Randomized traffic against the model
        for (int n = 0; n < 150; n++) begin
            op  = $urandom_range(0, 11);
            k   = 8'($urandom_range(0, 5));
            inv = ($urandom_range(0, 4) == 0) ? 8'($urandom) : ~k;
            c   = ($urandom_range(0, 4) == 0) ? 16'($urandom) : CODE;
            if (op <= 4)       send_frame({inv, k, c});
            else if (op <= 6)  do_pop("rand_pop");
            else if (op == 7)  frame_with_pop({inv, k, c}, "rand_frame_pop");
            else if (op == 8)  write_reg(A_CTRL, 32'($urandom_range(0, 3)));
            else if (op == 9)  write_reg(A_STAT, 32'($urandom_range(0, 3)));
            else if (op == 10) repeat (H) tick();
            else               repeat ($urandom_range(0, 5)) tick();
            check_status("rand_status");
            check_irq("rand_irq");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
